// File: rtl/barrett_pkg.sv
// barrett_pkg
//   Shared definitions for the Barrett constant generator.
//   - state_e  : controller state encoding (IDLE/NORM/DIV/FIN)
//   - DEF_Q_W  : default modulus width
//   - DEF_MU_W : default mu output width
//   - DEF_K_W  : default k output width
//   - DEF_CNT_W: default width of the division iteration counter (K_W+1,
//                since it must hold 2k for k up to Q_W)
package barrett_pkg;

    localparam int DEF_Q_W   = 64;
    localparam int DEF_MU_W  = 31;
    localparam int DEF_K_W   = 8;
    localparam int DEF_CNT_W = DEF_K_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/barrett_div_step.sv
// barrett_div_step
//   One iteration of bit-serial restoring division, purely combinational.
//   The partial remainder is shifted left by one, the next dividend bit is
//   appended, and the divisor is subtracted when it fits.
// Ports
//   r_i      [Q_W:0]   current partial remainder (always < q_i)
//   d_i                next dividend bit
//   q_i      [Q_W-1:0] divisor
//   r_next_o [Q_W:0]   partial remainder after this step
//   qb_o               quotient bit produced by this step
module barrett_div_step #(
    parameter int Q_W = 64
) (
    input  logic [Q_W:0]   r_i,
    input  logic           d_i,
    input  logic [Q_W-1:0] q_i,
    output logic [Q_W:0]   r_next_o,
    output logic           qb_o
);

    logic [Q_W+1:0] r_sh;
    logic [Q_W:0]   diff;

    assign r_sh = {r_i, d_i};
    assign qb_o = (r_sh >= {2'b00, q_i});
    // Only taken when r_sh >= q, so the difference is below q and the
    // discarded top bit of r_sh is irrelevant.
    assign diff     = r_sh[Q_W:0] - {1'b0, q_i};
    assign r_next_o = qb_o ? diff : r_sh[Q_W:0];

endmodule

// File: rtl/barrett_mu_precompute.sv
// barrett_mu_precompute
//   Sequential generator of Barrett constants for modulus q:
//     k  = bit length of q
//     mu = floor(2^(2k) / q)
//   One quotient bit per clock (restoring division). mu/k/err hold their
//   values until the next done pulse.
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  request, accepted only while busy is low
//   q      modulus, sampled on the accepting cycle
//   busy   high while a run is in progress
//   done   one-cycle pulse; mu/k/err valid from this cycle on
//   mu     floor(2^(2k)/q), 0 on error
//   k      bit length of q, 0 on error
//   err    q == 0 or the quotient does not fit in MU_W bits
// Configuration
//   BARRETT_PRE_CACHE_EN: remember the last successfully processed q; a
//   repeated request for it completes with done one cycle after acceptance
//   without recomputing and without raising busy.
module barrett_mu_precompute
    import barrett_pkg::*;
#(
    parameter int Q_W  = DEF_Q_W,
    parameter int MU_W = DEF_MU_W,
    parameter int K_W  = DEF_K_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [Q_W-1:0]  q,
    output logic            busy,
    output logic            done,
    output logic [MU_W-1:0] mu,
    output logic [K_W-1:0]  k,
    output logic            err
);

    localparam int CNT_W = K_W + 1;

    state_e           state_q;
    logic [Q_W-1:0]   q_q;
    logic [Q_W:0]     r_q;
    logic [MU_W-1:0]  quo_q;
    logic             ovf_q;
    logic [K_W-1:0]   kw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [MU_W-1:0]  mu_q;
    logic [K_W-1:0]   k_q;
    logic             err_q;

    // Leading-one detect: the highest set bit wins.
    logic [K_W-1:0] lod_k;
    always_comb begin
        lod_k = '0;
        for (int i = 0; i < Q_W; i++) begin
            if (q_q[i]) lod_k = K_W'(i + 1);
        end
    end

    // Division datapath
    logic            div_d;
    logic [Q_W:0]    r_next;
    logic            qb;
    logic [MU_W-1:0] quo_d;
    logic            ovf_d;
    logic            last_step;

    // The dividend 2^(2k) is a single one followed by 2k zeros.
    assign div_d     = (cnt_q == {kw_q, 1'b0});
    assign quo_d     = {quo_q[MU_W-2:0], qb};
    // Any bit pushed out of the top of the quotient register is sticky.
    assign ovf_d     = ovf_q | quo_q[MU_W-1];
    assign last_step = (state_q == ST_DIV) && (cnt_q == '0);

    barrett_div_step #(
        .Q_W (Q_W)
    ) u_div_step (
        .r_i      (r_q),
        .d_i      (div_d),
        .q_i      (q_q),
        .r_next_o (r_next),
        .qb_o     (qb)
    );

    logic cache_hit;

`ifdef BARRETT_PRE_CACHE_EN
    logic [Q_W-1:0] cache_q_q;
    logic           cache_vld_q;
    logic           fin_ok;
    logic           fin_err;

    assign fin_ok    = last_step && !ovf_d;
    assign fin_err   = ((state_q == ST_NORM) && (q_q == '0)) || (last_step && ovf_d);
    assign cache_hit = cache_vld_q && (q == cache_q_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_q_q   <= '0;
            cache_vld_q <= 1'b0;
        end else if (fin_ok) begin
            cache_q_q   <= q_q;
            cache_vld_q <= 1'b1;
        end else if (fin_err) begin
            cache_vld_q <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Controller. FIN is the done cycle and accepts a new start exactly
    // like IDLE does, so back-to-back runs lose no cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            ovf_q   <= 1'b0;
            kw_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mu_q    <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    state_q <= ST_IDLE;
                    if (start) begin
                        if (cache_hit) begin
                            // mu/k already describe this modulus.
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state_q <= ST_FIN;
                        end else begin
                            q_q     <= q;
                            r_q     <= '0;
                            quo_q   <= '0;
                            ovf_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_NORM;
                        end
                    end
                end
                ST_NORM: begin
                    if (q_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        mu_q    <= '0;
                        k_q     <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        kw_q    <= lod_k;
                        cnt_q   <= {lod_k, 1'b0};
                        state_q <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_q   <= r_next;
                    quo_q <= quo_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        mu_q    <= ovf_d ? '0 : quo_d;
                        k_q     <= ovf_d ? '0 : kw_q;
                        err_q   <= ovf_d;
                        state_q <= ST_FIN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign mu   = mu_q;
    assign k    = k_q;
    assign err  = err_q;

endmodule
